// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types and constants for the register-bus arbiter.
package reg_bus_arbiter_pkg;

  localparam int unsigned StateWidth = 2;

  typedef enum logic [StateWidth-1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StXfer  = 2'd2,
    StTurn  = 2'd3
  } state_e;

  localparam int unsigned DefNrOfReq  = 4;
  localparam int unsigned DefNrOfRegs = 8;
  localparam int unsigned DefAddrBits = 3;
  localparam int unsigned DefMaxAddr  = DefNrOfRegs - 1;

  // Highest register address that decodes to a real register.
  function automatic int unsigned max_addr(int unsigned nr_of_regs);
    return nr_of_regs - 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping.
module rr_priority_pick
  import reg_bus_arbiter_pkg::*;
#(
  parameter int unsigned NrOfReq = DefNrOfReq,
  parameter int unsigned IdxW    = 2
) (
  input  logic [NrOfReq-1:0] req,
  input  logic [IdxW-1:0]    rr_ptr,
  output logic [IdxW-1:0]    winner,
  output logic               valid
);

  localparam int unsigned SumW = IdxW + 1;

  always_comb begin
    logic [SumW-1:0] sum;
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    for (int unsigned off = 0; off < NrOfReq; off++) begin
      // rr_ptr and off are both below NrOfReq, so one subtraction wraps correctly.
      sum = {1'b0, rr_ptr} + SumW'(off);
      if (sum >= SumW'(NrOfReq)) begin
        sum = sum - SumW'(NrOfReq);
      end
      if (!valid && req[sum[IdxW-1:0]]) begin
        valid  = 1'b1;
        winner = sum[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one tri-state register bus among NrOfReq requesters.
// Define REG_BUS_TURNAROUND_EN to insert an idle TURN cycle after every transfer.
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int unsigned NrOfReq  = DefNrOfReq,
  parameter int unsigned NrOfRegs = DefNrOfRegs,
  parameter int unsigned AddrBits = DefAddrBits
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Tick,
  input  logic [NrOfReq-1:0]           req,
  input  logic [NrOfReq-1:0]           we,
  input  logic [NrOfReq*AddrBits-1:0]  addr,
  output logic [NrOfReq-1:0]           gnt,
  output logic [NrOfReq-1:0]           done,
  output logic                         err,
  output logic                         busy,
  output logic [NrOfRegs-1:0]          reg_cs,
  output logic [NrOfRegs-1:0]          reg_ce
);

  localparam int unsigned IdxW    = $clog2(NrOfReq);
  localparam int unsigned MaxAddr = max_addr(NrOfRegs);

  state_e state_q, state_d;

  logic [IdxW-1:0]     win_q;
  logic [IdxW-1:0]     rr_ptr_q;
  logic                we_q;
  logic [AddrBits-1:0] addr_q;

  logic [IdxW-1:0]     pick_idx;
  logic                pick_valid;
  logic [AddrBits-1:0] addr_arr [NrOfReq];
  logic                addr_ok;
  logic [NrOfRegs-1:0] reg_sel;
  logic                start;
  logic                finish;

  always_comb begin
    for (int i = 0; i < NrOfReq; i++) begin
      addr_arr[i] = addr[i*AddrBits +: AddrBits];
    end
  end

  rr_priority_pick #(
    .NrOfReq (NrOfReq),
    .IdxW    (IdxW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign start  = (state_q == StIdle) && Tick && pick_valid;
  assign finish = (state_q == StXfer) && Tick;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      win_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        win_q  <= pick_idx;
        we_q   <= we[pick_idx];
        addr_q <= addr_arr[pick_idx];
      end
      if (finish) begin
        rr_ptr_q <= (win_q == IdxW'(NrOfReq - 1)) ? '0 : win_q + 1'b1;
      end
    end
  end

  // Out-of-range addresses select nothing, so no cs/ce is ever asserted for them.
  always_comb begin
    addr_ok = (32'(addr_q) <= MaxAddr);
    for (int unsigned r = 0; r < NrOfRegs; r++) begin
      reg_sel[r] = addr_ok && (32'(addr_q) == r);
    end
  end

  always_comb begin
    state_d = state_q;
    gnt     = '0;
    done    = '0;
    err     = 1'b0;
    reg_cs  = '1;
    reg_ce  = '0;
    busy    = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StGrant;
        end
      end
      StGrant: begin
        gnt[win_q] = 1'b1;
        if (!we_q) begin
          reg_cs = ~reg_sel;
        end
        if (Tick) begin
          state_d = StXfer;
        end
      end
      StXfer: begin
        gnt[win_q]  = 1'b1;
        done[win_q] = Tick;
        err         = Tick && !addr_ok;
        if (!we_q) begin
          reg_cs = ~reg_sel;
        end else begin
          reg_ce = reg_sel & {NrOfRegs{Tick}};
        end
        if (Tick) begin
`ifdef REG_BUS_TURNAROUND_EN
          state_d = StTurn;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef REG_BUS_TURNAROUND_EN
      StTurn: begin
        if (Tick) begin
          state_d = StIdle;
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  cs_one_low_a : assert property (@(posedge Clock) disable iff (Reset)
    $countones(~reg_cs) <= 1);
  ce_not_with_cs_a : assert property (@(posedge Clock) disable iff (Reset)
    (reg_ce == '0) || (&reg_cs));

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model with its own register bank.
module tb_reg_bus_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned NG = 6;
  localparam int unsigned AW = 3;
`ifdef REG_BUS_TURNAROUND_EN
  localparam bit TurnEn = 1'b1;
`else
  localparam bit TurnEn = 1'b0;
`endif
  localparam int Gap = TurnEn ? 4 : 3;

  logic             Clock;
  logic             Reset;
  logic             Tick;
  logic [NR-1:0]    req;
  logic [NR-1:0]    we;
  logic [NR*AW-1:0] addr;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    done;
  logic             err;
  logic             busy;
  logic [NG-1:0]    reg_cs;
  logic [NG-1:0]    reg_ce;

  reg_bus_arbiter #(
    .NrOfReq  (NR),
    .NrOfRegs (NG),
    .AddrBits (AW)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Tick   (Tick),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .gnt    (gnt),
    .done   (done),
    .err    (err),
    .busy   (busy),
    .reg_cs (reg_cs),
    .reg_ce (reg_ce)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int         n_checks;
  int         n_fail;
  bit         chk_en;
  logic [7:0] wdata    [NR];
  logic [7:0] dut_bank [NG];
  logic [7:0] m_bank   [NG];

  // Transaction-level model: phase counts Tick edges since the winner was chosen.
  bit         m_act;
  int         m_phase;
  int         m_win;
  bit         m_we;
  int         m_addr;
  int         m_ptr;
  bit [NR-1:0] m_done_ev;
  bit [NR-1:0] pend;

  int rr_order [5];
  int rr_when  [5];
  int rr_got;
  int exp_order [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bus_data();
    logic [7:0] v = 8'h00;
    for (int i = 0; i < NR; i++) if (gnt[i] && we[i]) v = wdata[i];
    return v;
  endfunction

  function automatic logic [7:0] rd_bus();
    logic [7:0] v = 8'hEE;
    for (int r = 0; r < NG; r++) if (!reg_cs[r]) v = dut_bank[r];
    return v;
  endfunction

  function automatic int idx_of(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Bench-side register bank: captures the bus on any edge where its strobe is high.
  initial begin
    for (int r = 0; r < NG; r++) dut_bank[r] = 8'(r * 16 + 1);
    forever begin
      @(posedge Clock);
      for (int r = 0; r < NG; r++) if (reg_ce[r]) dut_bank[r] <= bus_data();
    end
  end

  task automatic model_reset();
    m_act     = 1'b0;
    m_phase   = 0;
    m_ptr     = 0;
    m_done_ev = '0;
  endtask

  task automatic model_step();
    m_done_ev = '0;
    if (!m_act) begin
      if (Tick && req != '0) begin
        for (int k = 0; k < NR; k++) begin
          int idx = (m_ptr + k) % NR;
          if (req[idx]) begin
            m_win = idx;
            break;
          end
        end
        m_we    = we[m_win];
        m_addr  = int'(addr[m_win*AW +: AW]);
        m_act   = 1'b1;
        m_phase = 0;
      end
    end else if (Tick) begin
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (m_we && m_addr < NG) m_bank[m_addr] = wdata[m_win];
        m_done_ev[m_win] = 1'b1;
        m_ptr = (m_win + 1) % NR;
        if (TurnEn) m_phase = 2;
        else m_act = 1'b0;
      end else begin
        m_act = 1'b0;
      end
    end
  endtask

  task automatic tick_cycle();
    @(posedge Clock);
    if (Reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic run_idle(input int n);
    req  = '0;
    Tick = 1'b1;
    repeat (n) tick_cycle();
  endtask

  task automatic drive_random();
    Tick = ($urandom_range(0, 7) != 0);
    for (int i = 0; i < NR; i++) begin
      if (m_done_ev[i]) begin
        pend[i] = 1'b0;
        req[i]  = 1'b0;
      end else if (!pend[i]) begin
        we[i]            = 1'($urandom_range(0, 1));
        addr[i*AW +: AW] = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          req[i]   = 1'b1;
          wdata[i] = 8'($urandom);
        end
      end else if (m_act && m_win == i && req[i] && $urandom_range(0, 5) == 0) begin
        req[i] = 1'b0;
      end
    end
  endtask

  // Every-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge Clock) begin
    logic [NR-1:0] e_gnt;
    logic [NR-1:0] e_done;
    logic [NG-1:0] e_cs;
    logic [NG-1:0] e_ce;
    bit            xfer;
    bit            valid;
    if (chk_en && !Reset) begin
      xfer   = m_act && m_phase == 1;
      valid  = m_addr < NG;
      e_gnt  = (m_act && m_phase < 2) ? (NR'(1) << m_win) : '0;
      e_done = (xfer && Tick) ? (NR'(1) << m_win) : '0;
      e_cs   = '1;
      if (m_act && m_phase < 2 && !m_we && valid) e_cs[m_addr] = 1'b0;
      e_ce   = '0;
      if (xfer && Tick && m_we && valid) e_ce[m_addr] = 1'b1;
      check("busy", 32'(busy), 32'(m_act));
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("done", 32'(done), 32'(e_done));
      check("err", 32'(err), 32'(xfer && Tick && !valid));
      check("reg_cs", 32'(reg_cs), 32'(e_cs));
      check("reg_ce", 32'(reg_ce), 32'(e_ce));
      check("cs_low_at_most_one", 32'($countones(~reg_cs) <= 1), 32'd1);
      check("ce_without_cs", 32'((reg_ce == '0) || (&reg_cs)), 32'd1);
      if (xfer && !m_we && valid) check("read_data", 32'(rd_bus()), 32'(m_bank[m_addr]));
      for (int r = 0; r < NG; r++) check("bank", 32'(dut_bank[r]), 32'(m_bank[r]));
    end
  end

  initial begin
    Reset    = 1'b1;
    Tick     = 1'b0;
    req      = '0;
    we       = '0;
    addr     = '0;
    pend     = '0;
    chk_en   = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    m_win    = 0;
    m_we     = 1'b0;
    m_addr   = 0;
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NR; i++) wdata[i] = 8'h00;
    for (int r = 0; r < NG; r++) m_bank[r] = 8'(r * 16 + 1);
    model_reset();
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_cs", 32'(reg_cs), 32'h3F);
    check("rst_ce", 32'(reg_ce), 32'h0);
    tick_cycle();
    tick_cycle();
    Reset  = 1'b0;
    Tick   = 1'b1;
    chk_en = 1'b1;

    // Write from requester 0 to register 5.
    req = 4'b0001; we = 4'b0001; addr = '0; addr[2:0] = 3'd5; wdata[0] = 8'hA5;
    tick_cycle();
    check("wr_grant_gnt", 32'(gnt), 32'h1);
    check("wr_grant_cs", 32'(reg_cs), 32'h3F);
    tick_cycle();
    check("wr_xfer_ce", 32'(reg_ce), 32'h20);
    check("wr_xfer_done", 32'(done), 32'h1);
    req = '0;
    tick_cycle();
    check("wr_commit", 32'(dut_bank[5]), 32'hA5);
    run_idle(3);

    // Reset during the XFER of a write to register 3 must not commit it.
    req = 4'b0010; we = 4'b0010; addr = '0; addr[5:3] = 3'd3; wdata[1] = 8'h11;
    tick_cycle();
    tick_cycle();
    req = '0;
    run_idle(3);
    check("pre_write_reg3", 32'(dut_bank[3]), 32'h11);
    req = 4'b0010; wdata[1] = 8'h77;
    tick_cycle();
    tick_cycle();
    check("mid_xfer_ce", 32'(reg_ce), 32'h08);
    #1;
    Reset = 1'b1;
    model_reset();
    #1;
    check("rst_mid_cs", 32'(reg_cs), 32'h3F);
    check("rst_mid_ce", 32'(reg_ce), 32'h0);
    check("rst_mid_gnt", 32'(gnt), 32'h0);
    tick_cycle();
    check("rst_reg3_kept", 32'(dut_bank[3]), 32'h11);
    req   = '0;
    Reset = 1'b0;
    run_idle(2);

    // All four requesters read, held high: strict rotation starting at 0.
    req = 4'b1111; we = '0; addr = {3'd3, 3'd2, 3'd1, 3'd0};
    rr_got = 0;
    for (int c = 1; c <= 40 && rr_got < 5; c++) begin
      tick_cycle();
      if (done != '0) begin
        rr_order[rr_got] = idx_of(done);
        rr_when[rr_got]  = c;
        rr_got++;
      end
    end
    check("rr_done_count", 32'(rr_got), 32'd5);
    if (rr_got == 5) begin
      check("rr_first_latency", 32'(rr_when[0]), 32'd2);
      for (int k = 0; k < 5; k++) check("rr_order", 32'(rr_order[k]), 32'(exp_order[k]));
      for (int k = 1; k < 5; k++) check("rr_gap", 32'(rr_when[k] - rr_when[k-1]), 32'(Gap));
    end
    run_idle(6);

    // Tick held low for three cycles while in GRANT.
    req = 4'b0010; we = '0; addr = '0; addr[5:3] = 3'd4;
    tick_cycle();
    check("stall_gnt0", 32'(gnt), 32'h2);
    Tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick_cycle();
      check("stall_gnt", 32'(gnt), 32'h2);
      check("stall_done", 32'(done), 32'h0);
      check("stall_ce", 32'(reg_ce), 32'h0);
      check("stall_cs", 32'(reg_cs), 32'h2F);
    end
    Tick = 1'b1;
    tick_cycle();
    check("stall_resume_done", 32'(done), 32'h2);
    run_idle(4);

    // Requester 2 reads address 7, beyond the six-register bank.
    req = 4'b0100; we = '0; addr = '0; addr[8:6] = 3'd7;
    tick_cycle();
    check("oor_grant_cs", 32'(reg_cs), 32'h3F);
    tick_cycle();
    check("oor_xfer_cs", 32'(reg_cs), 32'h3F);
    check("oor_err", 32'(err), 32'h1);
    check("oor_done", 32'(done), 32'h4);
    run_idle(4);

    // Randomized traffic with Tick stalls and mid-transaction request drops.
    for (int c = 0; c < 1500; c++) begin
      tick_cycle();
      drive_random();
    end
    run_idle(10);
    check("drain_idle", 32'(busy), 32'h0);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
